// File: rtl/emu_clk_pkg.sv
// Shared time type, constants and helpers for the emulated-clock generator.
package emu_clk_pkg;

  localparam int DT_WIDTH = 32;

  typedef logic [DT_WIDTH-1:0] dt_t;

  localparam dt_t DT_MAX = '1;

  // A zero-length phase would stall the time manager, so the shortest phase is one unit.
  function automatic dt_t clamp1(input dt_t v);
    return (v == '0) ? dt_t'(1) : v;
  endfunction

endpackage

// File: rtl/emu_clk_cfg.sv
// Phase-duration configuration: shadow registers filled by a valid/ready handshake,
// swapped into the active registers only on a clock edge so a phase is never altered.
module emu_clk_cfg #(
  parameter int                  DT_WIDTH = 32,
  parameter logic [DT_WIDTH-1:0] TLO_DEF  = 50,
  parameter logic [DT_WIDTH-1:0] THI_DEF  = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                edge_stb_i,
  input  logic                cfg_valid_i,
  input  logic [DT_WIDTH-1:0] cfg_tlo_i,
  input  logic [DT_WIDTH-1:0] cfg_thi_i,
  output logic                cfg_ready_o,
  output logic [DT_WIDTH-1:0] nxt_tlo_o,
  output logic [DT_WIDTH-1:0] nxt_thi_o
);
  import emu_clk_pkg::*;

  logic [DT_WIDTH-1:0] act_tlo_q, act_tlo_d;
  logic [DT_WIDTH-1:0] act_thi_q, act_thi_d;
  logic [DT_WIDTH-1:0] shd_tlo_q, shd_tlo_d;
  logic [DT_WIDTH-1:0] shd_thi_q, shd_thi_d;
  logic                pend_q, pend_d;

  // Durations an edge taken this cycle reloads from (pending config wins).
  assign nxt_tlo_o   = pend_q ? clamp1(shd_tlo_q) : act_tlo_q;
  assign nxt_thi_o   = pend_q ? clamp1(shd_thi_q) : act_thi_q;
  assign cfg_ready_o = !pend_q;

  always_comb begin
    act_tlo_d = act_tlo_q;
    act_thi_d = act_thi_q;
    shd_tlo_d = shd_tlo_q;
    shd_thi_d = shd_thi_q;
    pend_d    = pend_q;
    if (edge_stb_i && pend_q) begin
      act_tlo_d = nxt_tlo_o;
      act_thi_d = nxt_thi_o;
      pend_d    = 1'b0;
    end
    // ready is low while pending, so a transfer never collides with a swap
    if (cfg_valid_i && !pend_q) begin
      shd_tlo_d = cfg_tlo_i;
      shd_thi_d = cfg_thi_i;
      pend_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_tlo_q <= clamp1(TLO_DEF);
      act_thi_q <= clamp1(THI_DEF);
      shd_tlo_q <= '0;
      shd_thi_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      act_tlo_q <= act_tlo_d;
      act_thi_q <= act_thi_d;
      shd_tlo_q <= shd_tlo_d;
      shd_thi_q <= shd_thi_d;
      pend_q    <= pend_d;
    end
  end

endmodule

// File: rtl/emu_clk_gen.sv
// Emulated-clock generator: requests the time to its next edge each emulator cycle and
// advances its phase counter by the granted step, toggling the emulated clock on edges.
module emu_clk_gen #(
  parameter int                  DT_WIDTH = 32,
  parameter logic [DT_WIDTH-1:0] TLO_DEF  = 50,
  parameter logic [DT_WIDTH-1:0] THI_DEF  = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [DT_WIDTH-1:0] emu_dt,
  output logic [DT_WIDTH-1:0] dt_req,
  output logic                clk_val,
  output logic                clk_en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [DT_WIDTH-1:0] cfg_tlo,
  input  logic [DT_WIDTH-1:0] cfg_thi,
  output logic                err
);
  import emu_clk_pkg::*;

  logic [DT_WIDTH-1:0] t_rem_q, t_rem_d;
  logic                clk_val_q, clk_val_d;
  logic                clk_en_q, clk_en_d;
  logic                err_q, err_d;
  logic                take_edge;
  logic [DT_WIDTH-1:0] nxt_tlo, nxt_thi;

  // An overshooting grant still counts as an edge; the excess is dropped.
  assign take_edge = enable && (emu_dt != '0) && (emu_dt >= t_rem_q);

  emu_clk_cfg #(
    .DT_WIDTH (DT_WIDTH),
    .TLO_DEF  (TLO_DEF),
    .THI_DEF  (THI_DEF)
  ) u_cfg (
    .clk         (clk),
    .rst         (rst),
    .edge_stb_i  (take_edge),
    .cfg_valid_i (cfg_valid),
    .cfg_tlo_i   (cfg_tlo),
    .cfg_thi_i   (cfg_thi),
    .cfg_ready_o (cfg_ready),
    .nxt_tlo_o   (nxt_tlo),
    .nxt_thi_o   (nxt_thi)
  );

  always_comb begin
    t_rem_d   = t_rem_q;
    clk_val_d = clk_val_q;
    clk_en_d  = 1'b0;
    err_d     = err_q;
    if (take_edge) begin
      clk_val_d = !clk_val_q;
      t_rem_d   = clk_val_q ? nxt_tlo : nxt_thi;
      clk_en_d  = !clk_val_q;
      if (emu_dt > t_rem_q) err_d = 1'b1;
    end else if (enable && emu_dt != '0) begin
      t_rem_d = t_rem_q - emu_dt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_rem_q   <= clamp1(TLO_DEF);
      clk_val_q <= 1'b0;
      clk_en_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      t_rem_q   <= t_rem_d;
      clk_val_q <= clk_val_d;
      clk_en_q  <= clk_en_d;
      err_q     <= err_d;
    end
  end

  assign dt_req  = enable ? t_rem_q : '1;
  assign clk_val = clk_val_q;
  assign clk_en  = clk_en_q;
  assign err     = err_q;

endmodule

// File: tb/tb_emu_clk_gen.sv
// Randomized self-checking bench for emu_clk_gen against a phase-elapsed-time model.
module tb_emu_clk_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] emu_dt;
  logic [31:0] dt_req;
  logic        clk_val;
  logic        clk_en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_tlo;
  logic [31:0] cfg_thi;
  logic        err;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: phase length and time spent in it, plus a queue of not-yet-applied configs.
  logic [31:0] m_len, m_elapsed, m_tlo, m_thi;
  logic        m_val, m_en, m_err;
  logic [63:0] m_pendq[$];

  emu_clk_gen #(.DT_WIDTH(32), .TLO_DEF(50), .THI_DEF(50)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .emu_dt    (emu_dt),
    .dt_req    (dt_req),
    .clk_val   (clk_val),
    .clk_en    (clk_en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_tlo   (cfg_tlo),
    .cfg_thi   (cfg_thi),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] clampm(input logic [31:0] v);
    return (v == 0) ? 32'd1 : v;
  endfunction

  function automatic logic [31:0] m_rem();
    return m_len - m_elapsed;
  endfunction

  task automatic model_reset();
    m_tlo = 50; m_thi = 50; m_len = 50; m_elapsed = 0;
    m_val = 0; m_en = 0; m_err = 0;
    m_pendq.delete();
  endtask

  task automatic model_step();
    logic xfer;
    logic [63:0] p;
    if (rst) begin
      model_reset();
      return;
    end
    xfer = cfg_valid && (m_pendq.size() == 0);
    m_en = 0;
    if (enable && emu_dt != 0) begin
      if (emu_dt < m_rem()) begin
        m_elapsed = m_elapsed + emu_dt;
      end else begin
        if (emu_dt > m_rem()) m_err = 1;
        m_val = !m_val;
        if (m_pendq.size() != 0) begin
          p = m_pendq.pop_front();
          m_tlo = clampm(p[63:32]);
          m_thi = clampm(p[31:0]);
        end
        m_len = m_val ? m_thi : m_tlo;
        m_elapsed = 0;
        m_en = m_val;
      end
    end
    if (xfer) m_pendq.push_back({cfg_tlo, cfg_thi});
  endtask

  task automatic step(input logic en, input logic [31:0] dt, input logic cv,
                      input logic [31:0] tlo, input logic [31:0] thi, input logic r);
    @(negedge clk);
    rst = r; enable = en; emu_dt = dt; cfg_valid = cv; cfg_tlo = tlo; cfg_thi = thi;
    #1;
    check_val("dt_req", dt_req, en ? m_rem() : 32'hFFFF_FFFF);
    @(posedge clk);
    model_step();
    #1;
    check_val("clk_val", {31'd0, clk_val}, {31'd0, m_val});
    check_val("clk_en", {31'd0, clk_en}, {31'd0, m_en});
    check_val("cfg_ready", {31'd0, cfg_ready}, {31'd0, (m_pendq.size() == 0)});
    check_val("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic run_exact(input int n);
    for (int i = 0; i < n; i++) step(1, m_rem(), 0, 0, 0, 0);
  endtask

  initial begin
    logic [31:0] hold_rem;
    logic        hold_val;
    int          sel;
    logic [31:0] dt;

    rst = 1; enable = 1; emu_dt = 0; cfg_valid = 0; cfg_tlo = 0; cfg_thi = 0;
    repeat (2) @(posedge clk);
    model_reset();
    #1;
    check_val("rst_clk_val", {31'd0, clk_val}, 32'd0);
    check_val("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
    check_val("rst_err", {31'd0, err}, 32'd0);
    check_val("rst_clk_en", {31'd0, clk_en}, 32'd0);

    // Exact grants: clock toggles every cycle, clk_en on each rise.
    step(1, 0, 0, 0, 0, 0);
    check_val("rst_dt_req", dt_req, 32'd50);
    for (int i = 1; i <= 6; i++) begin
      step(1, m_rem(), 0, 0, 0, 0);
      check_val("exact_val", {31'd0, clk_val}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check_val("exact_en", {31'd0, clk_en}, (i % 2 == 1) ? 32'd1 : 32'd0);
    end

    // Constant step of 20: 50 -> 30 -> 10 -> overshoot.
    step(1, 0, 0, 0, 0, 1);
    step(1, 20, 0, 0, 0, 0);
    step(1, 20, 0, 0, 0, 0);
    check_val("dt20_rem", dt_req, 32'd10);
    step(1, 20, 0, 0, 0, 0);
    check_val("dt20_err", {31'd0, err}, 32'd1);
    check_val("dt20_val", {31'd0, clk_val}, 32'd1);
    run_exact(4);
    check_val("err_sticky", {31'd0, err}, 32'd1);

    // New config mid low phase.
    step(1, 0, 0, 0, 0, 1);
    step(1, 5, 0, 0, 0, 0);
    step(1, 5, 1, 10, 30, 0);
    check_val("cfg_ready_drop", {31'd0, cfg_ready}, 32'd0);
    step(1, m_rem(), 0, 0, 0, 0);
    check_val("cfg_rise_thi", dt_req, 32'd30);
    check_val("cfg_ready_back", {31'd0, cfg_ready}, 32'd1);
    step(1, 30, 0, 0, 0, 0);
    check_val("cfg_fall_tlo", dt_req, 32'd10);

    // Freeze with random grants, then resume.
    step(1, 3, 0, 0, 0, 0);
    hold_rem = m_rem();
    hold_val = m_val;
    for (int i = 0; i < 5; i++) step(0, $urandom, 0, 0, 0, 0);
    check_val("frz_val", {31'd0, clk_val}, {31'd0, hold_val});
    step(1, 0, 0, 0, 0, 0);
    check_val("frz_rem", dt_req, hold_rem);

    // Zero durations clamp to one unit.
    step(1, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    step(1, m_rem(), 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 0);
    check_val("zero_dt_req", dt_req, 32'd1);

    // Reset while a config is pending discards it.
    step(1, 0, 0, 0, 0, 1);
    step(1, 33, 0, 0, 0, 0);
    step(1, 0, 1, 7, 9, 0);
    check_val("pre_rst_rem", dt_req, 32'd17);
    step(1, 0, 0, 0, 0, 1);
    check_val("post_rst_rem", dt_req, 32'd50);
    check_val("post_rst_ready", {31'd0, cfg_ready}, 32'd1);
    run_exact(2);
    check_val("discard_tlo", dt_req, 32'd50);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0:       dt = 0;
        1, 2, 3, 4: dt = m_rem();
        5, 6, 7: dt = $urandom_range(1, m_rem());
        8:       dt = m_rem() + $urandom_range(1, 100);
        default: dt = $urandom;
      endcase
      step(($urandom_range(0, 9) != 0), dt, ($urandom_range(0, 3) == 0),
           $urandom_range(0, 40), $urandom_range(0, 40), ($urandom_range(0, 99) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
